simple_router: RTL
==================

Name: simple_router

Overview:
- Sequential bus router that sits directly downstream of the address decoder.
- Takes one master request plus the decoder's per-slave `sel` vector, latches the transaction and drives it to exactly one slave.
- Waits for that slave's ack and returns read data and ack/err to the master.
- Unmapped addresses get an error response from the router itself.

Parameters:
- slv_c, 4, number of slave ports; must match the decoder's slv_c.
- TIMEOUT, 255, maximum WAIT cycles before an error response; only used with the optional feature.
- ERR_RDATA, 32'h0000_0000, read data returned on any error response.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- m_addr  input  32  master address; also driven to the decoder.
- m_we  input  1  master write enable.
- m_wd  input  32  master write data.
- m_req  input  1  master request; held high until m_ack is sampled.
- m_ack  output  1  single-cycle response strobe.
- m_err  output  1  error flag, valid only when m_ack=1.
- m_rd  output  32  read data, valid only when m_ack=1.
- sel  input  slv_c  one-hot-ish select from the decoder for the current m_addr.
- s_addr  output  32  latched address, broadcast to all slaves.
- s_we  output  1  latched write enable, broadcast.
- s_wd  output  32  latched write data, broadcast.
- s_req  output  slv_c  per-slave request; at most one bit set.
- s_ack  input  slv_c  per-slave ack.
- s_rd  input  [slv_c-1:0][31:0]  per-slave read data.

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, s_req=0, s_addr/s_we/s_wd=0, m_ack=0, m_err=0, m_rd=0.
- Reset mid-transaction: the in-flight access is abandoned with no response; s_req is low in the cycle after the reset edge.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE, m_req=1, sel!=0:
  - Latch m_addr/m_we/m_wd into s_*.
  - Latch idx = lowest set bit of sel; multiple set bits means the lowest index wins.
  - Set s_req[idx]=1 and go to WAIT.
- IDLE, m_req=1, sel=0: set m_err_r=1, m_rd_r=ERR_RDATA, go to RESP.
- IDLE, m_req=0: stay in IDLE.
- WAIT:
  - s_req[idx] is held at 1 and s_* are held stable.
  - s_ack on non-selected ports is ignored.
  - On s_ack[idx]=1: capture s_rd[idx] into m_rd, m_err=0, clear s_req, go to RESP.
- RESP: m_ack=1 for exactly one cycle, then IDLE.
- Master contract: m_req drops on the edge that samples m_ack=1. A new request may arrive in the first IDLE cycle after RESP.
- m_req and sel are sampled only in IDLE. Changes to m_addr/m_req during WAIT/RESP have no effect.
- Latency:
  - Accept edge t gives s_req high in cycle t+1.
  - Slave ack in cycle k gives m_ack in cycle k+1.
  - Unmapped access: m_ack in cycle t+1.
  - Minimum mapped round trip, with a zero-wait slave acking the first s_req cycle, is m_ack 2 cycles after acceptance.
- m_ack and s_req are never high together for the same transaction cycle.

Optional Feature:
- Macro: SIMPLE_ROUTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT without s_ack[idx]: drop s_req, m_err=1, m_rd=ERR_RDATA, go to RESP.
  - If ack and timeout occur in the same cycle, the ack wins.
- Undefined: no counter; WAIT lasts until s_ack[idx] indefinitely.

Decomposition:
- Shared package simple_bus_pkg:
  - State enum type for IDLE/WAIT/RESP.
  - Bus width constant (32).
  - Default ERR_RDATA constant.
- One sub-module, simple_pri_enc: slv_c-bit vector in; outputs lowest-set-bit index ($clog2(slv_c) bits) and a `valid` flag. Instantiated once for sel.

Test Plan:
- Write to slave 2, sel=4'b0100, m_addr=0x0000_2004, m_wd=0xA5A5_0001, slave acks after 3 wait cycles -> s_req=4'b0100 for 4 cycles with s_wd=0xA5A5_0001; m_ack=1, m_err=0 one cycle after the ack.
- Read slave 0, s_rd[0]=0x1234_5678, zero-wait ack -> m_rd=0x1234_5678, m_ack one cycle after s_ack; total 2 cycles after acceptance.
- Unmapped, sel=0 -> no s_req bit ever set; m_ack=1, m_err=1, m_rd=0x0 in the cycle after the request.
- Overlapping sel=4'b1010 -> only s_req[1] asserted; stray s_ack[3]=1 during WAIT is ignored.
- rst=1 during WAIT to slave 1 -> next cycle s_req=0, m_ack=0, state IDLE; a following request to slave 3 completes normally.
- With SIMPLE_ROUTER_TIMEOUT_EN, TIMEOUT=8, slave never acks -> s_req drops after 8 WAIT cycles; m_ack=1, m_err=1. Ack on exactly cycle 8 -> m_err=0.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple bus router: FSM state encoding,
// bus width and the default read data returned on error responses.
package simple_bus_pkg;

  localparam int BUS_W = 32;

  localparam logic [BUS_W-1:0] ERR_RDATA_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/simple_pri_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit of
// vec_i and a valid flag that is high when any bit is set.
module simple_pri_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = {W{1'b0}};
    valid_o = |vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/simple_router.sv
// Sequential bus router: latches one master request, forwards it to the
// lowest selected slave and returns that slave's response; unmapped accesses
// get an error response. Define SIMPLE_ROUTER_TIMEOUT_EN to add a WAIT timeout.
module simple_router
  import simple_bus_pkg::*;
#(
  parameter int               slv_c     = 4,
  parameter int               TIMEOUT   = 255,
  parameter logic [BUS_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_W-1:0]             m_addr,
  input  logic                         m_we,
  input  logic [BUS_W-1:0]             m_wd,
  input  logic                         m_req,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [BUS_W-1:0]             m_rd,
  input  logic [slv_c-1:0]             sel,
  output logic [BUS_W-1:0]             s_addr,
  output logic                         s_we,
  output logic [BUS_W-1:0]             s_wd,
  output logic [slv_c-1:0]             s_req,
  input  logic [slv_c-1:0]             s_ack,
  input  logic [slv_c-1:0][BUS_W-1:0]  s_rd
);

  localparam int IDX_W = (slv_c > 1) ? $clog2(slv_c) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [slv_c-1:0]   s_req_q;
  logic [BUS_W-1:0]   s_addr_q;
  logic               s_we_q;
  logic [BUS_W-1:0]   s_wd_q;
  logic               m_ack_q;
  logic               m_err_q;
  logic [BUS_W-1:0]   m_rd_q;

  logic [IDX_W-1:0]   sel_idx_s;
  logic               sel_vld_s;
  logic [slv_c-1:0]   onehot_s;
  logic               ack_hit_s;
  logic [BUS_W-1:0]   rd_sel_s;

`ifdef SIMPLE_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   to_cnt_q;
`else
  logic               unused_s;
  assign unused_s = ^TIMEOUT;
`endif

  simple_pri_enc #(
    .N (slv_c),
    .W (IDX_W)
  ) u_sel_enc (
    .vec_i   (sel),
    .idx_o   (sel_idx_s),
    .valid_o (sel_vld_s)
  );

  assign onehot_s  = {{(slv_c-1){1'b0}}, 1'b1} << sel_idx_s;
  assign ack_hit_s = s_ack[idx_q];
  assign rd_sel_s  = s_rd[idx_q];

  // Router FSM; every output is a register written only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      s_req_q  <= {slv_c{1'b0}};
      s_addr_q <= {BUS_W{1'b0}};
      s_we_q   <= 1'b0;
      s_wd_q   <= {BUS_W{1'b0}};
      m_ack_q  <= 1'b0;
      m_err_q  <= 1'b0;
      m_rd_q   <= {BUS_W{1'b0}};
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
      to_cnt_q <= {CNT_W{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          m_ack_q <= 1'b0;
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
          to_cnt_q <= {CNT_W{1'b0}};
`endif
          if (m_req) begin
            if (sel_vld_s) begin
              s_addr_q <= m_addr;
              s_we_q   <= m_we;
              s_wd_q   <= m_wd;
              idx_q    <= sel_idx_s;
              s_req_q  <= onehot_s;
              state_q  <= ST_WAIT;
            end else begin
              m_err_q  <= 1'b1;
              m_rd_q   <= ERR_RDATA;
              m_ack_q  <= 1'b1;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          // Acks from ports other than the selected one are never looked at.
          if (ack_hit_s) begin
            m_rd_q  <= rd_sel_s;
            m_err_q <= 1'b0;
            m_ack_q <= 1'b1;
            s_req_q <= {slv_c{1'b0}};
            state_q <= ST_RESP;
          end
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
          else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            m_rd_q  <= ERR_RDATA;
            m_err_q <= 1'b1;
            m_ack_q <= 1'b1;
            s_req_q <= {slv_c{1'b0}};
            state_q <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          m_ack_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          m_ack_q <= 1'b0;
          s_req_q <= {slv_c{1'b0}};
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_ack  = m_ack_q;
  assign m_err  = m_err_q;
  assign m_rd   = m_rd_q;
  assign s_addr = s_addr_q;
  assign s_we   = s_we_q;
  assign s_wd   = s_wd_q;
  assign s_req  = s_req_q;

endmodule
